// File: rtl/mathb_mac_array.sv
// Math-block MAC array: fifteen concurrent multiply-accumulate lanes in four
// precisions (1x32, 2x16, 4x8, 8x4) sharing one operand and one coefficient word.

// One MAC lane of width N: 2N-bit wrapping accumulator followed by a
// combinational shift / round / saturate output stage.
module mathb_mac_lane #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [N-1:0] i_oper,
  input  logic [N-1:0] i_coef,
  input  logic         i_tc,
  input  logic         i_clear,
  input  logic         i_rnd,
  input  logic         i_sat,
  input  logic [5:0]   i_sel,
  output logic [N-1:0] o_out
);

  localparam int W = 2 * N;

  logic [W-1:0]   r_acc;
  logic [W-1:0]   w_oper_ext;
  logic [W-1:0]   w_coef_ext;
  logic [W-1:0]   w_prod;
  logic [5:0]     w_s;
  logic [W:0]     w_wide;
  logic [W:0]     w_rnd_add;
  logic [W:0]     w_sum;
  logic [W:0]     w_shr_l;
  logic [W:0]     w_shr_a;
  logic [W:0]     w_shr;
  logic [N+1:0]   w_top_s;
  logic           w_ovf_s;
  logic           w_ovf_u;

  // Extending both slices to 2N bits makes the low 2N bits of the product
  // exact for signed and unsigned operands alike.
  assign w_oper_ext = {{N{i_tc & i_oper[N-1]}}, i_oper};
  assign w_coef_ext = {{N{i_tc & i_coef[N-1]}}, i_coef};
  assign w_prod     = w_oper_ext * w_coef_ext;

  // NOTE: clocked state is written only with <=, so every lane sees the
  // accumulator value from before the edge regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= i_clear ? w_prod : (r_acc + w_prod);
    end
  end

  assign w_s       = (i_sel > 6'(N)) ? 6'(N) : i_sel;
  assign w_wide    = {i_tc & r_acc[W-1], r_acc};
  assign w_rnd_add = (i_rnd && (w_s != 6'd0)) ? ({{W{1'b0}}, 1'b1} << (w_s - 6'd1)) : '0;
  assign w_sum     = w_wide + w_rnd_add;
  assign w_shr_a   = $signed(w_sum) >>> w_s;
  assign w_shr_l   = w_sum >> w_s;
  assign w_shr     = i_tc ? w_shr_a : w_shr_l;

  // Signed result fits in N bits only if bits [W:N-1] are all copies of the sign.
  assign w_top_s = w_shr[W:N-1];
  assign w_ovf_s = !((&w_top_s) || (~|w_top_s));
  assign w_ovf_u = |w_shr[W:N];

  // NOTE: o_out gets its default before any branch, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    o_out = w_shr[N-1:0];
    if (i_sat) begin
      if (i_tc) begin
        if (w_ovf_s) begin
          o_out = w_shr[W] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
      end else if (w_ovf_u) begin
        o_out = '1;
      end
    end
  end

endmodule

module mathb_mac_array (
  input  logic        MAC_ACC_CLK,
  input  logic        acc_ff_rstn,
  input  logic        EFPGA_MATHB_CLK_EN,
  input  logic [31:0] MAC_OPER_DATA,
  input  logic [31:0] MAC_COEF_DATA,
  input  logic        MAC_TC,
  input  logic        MAC_ACC_CLEAR,
  input  logic        MAC_ACC_RND,
  input  logic        MAC_ACC_SAT,
  input  logic [5:0]  MAC_OUT_SEL,
  output logic [31:0] MAC0_OUT,
  output logic [15:0] MAC1_OUT,
  output logic [15:0] MAC2_OUT,
  output logic [7:0]  MAC3_OUT,
  output logic [7:0]  MAC4_OUT,
  output logic [7:0]  MAC5_OUT,
  output logic [7:0]  MAC6_OUT,
  output logic [3:0]  MAC_4_7_OUT,
  output logic [3:0]  MAC_4_6_OUT,
  output logic [3:0]  MAC_4_5_OUT,
  output logic [3:0]  MAC_4_4_OUT,
  output logic [3:0]  MAC_4_3_OUT,
  output logic [3:0]  MAC_4_2_OUT,
  output logic [3:0]  MAC_4_1_OUT,
  output logic [3:0]  MAC_4_0_OUT
);

  logic [31:0] w_out32;
  logic [15:0] w_out16 [2];
  logic [7:0]  w_out8  [4];
  logic [3:0]  w_out4  [8];

  mathb_mac_lane #(.N(32)) u_lane32 (
    .i_clk   (MAC_ACC_CLK),
    .i_rstn  (acc_ff_rstn),
    .i_en    (EFPGA_MATHB_CLK_EN),
    .i_oper  (MAC_OPER_DATA),
    .i_coef  (MAC_COEF_DATA),
    .i_tc    (MAC_TC),
    .i_clear (MAC_ACC_CLEAR),
    .i_rnd   (MAC_ACC_RND),
    .i_sat   (MAC_ACC_SAT),
    .i_sel   (MAC_OUT_SEL),
    .o_out   (w_out32)
  );

  // Lane g of each precision always takes operand bits [N*g +: N].
  for (genvar g = 0; g < 2; g++) begin : g_lane16
    mathb_mac_lane #(.N(16)) u_lane (
      .i_clk   (MAC_ACC_CLK),
      .i_rstn  (acc_ff_rstn),
      .i_en    (EFPGA_MATHB_CLK_EN),
      .i_oper  (MAC_OPER_DATA[16*g +: 16]),
      .i_coef  (MAC_COEF_DATA[16*g +: 16]),
      .i_tc    (MAC_TC),
      .i_clear (MAC_ACC_CLEAR),
      .i_rnd   (MAC_ACC_RND),
      .i_sat   (MAC_ACC_SAT),
      .i_sel   (MAC_OUT_SEL),
      .o_out   (w_out16[g])
    );
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane8
    mathb_mac_lane #(.N(8)) u_lane (
      .i_clk   (MAC_ACC_CLK),
      .i_rstn  (acc_ff_rstn),
      .i_en    (EFPGA_MATHB_CLK_EN),
      .i_oper  (MAC_OPER_DATA[8*g +: 8]),
      .i_coef  (MAC_COEF_DATA[8*g +: 8]),
      .i_tc    (MAC_TC),
      .i_clear (MAC_ACC_CLEAR),
      .i_rnd   (MAC_ACC_RND),
      .i_sat   (MAC_ACC_SAT),
      .i_sel   (MAC_OUT_SEL),
      .o_out   (w_out8[g])
    );
  end

  for (genvar g = 0; g < 8; g++) begin : g_lane4
    mathb_mac_lane #(.N(4)) u_lane (
      .i_clk   (MAC_ACC_CLK),
      .i_rstn  (acc_ff_rstn),
      .i_en    (EFPGA_MATHB_CLK_EN),
      .i_oper  (MAC_OPER_DATA[4*g +: 4]),
      .i_coef  (MAC_COEF_DATA[4*g +: 4]),
      .i_tc    (MAC_TC),
      .i_clear (MAC_ACC_CLEAR),
      .i_rnd   (MAC_ACC_RND),
      .i_sat   (MAC_ACC_SAT),
      .i_sel   (MAC_OUT_SEL),
      .o_out   (w_out4[g])
    );
  end

  assign MAC0_OUT    = w_out32;
  assign MAC1_OUT    = w_out16[1];
  assign MAC2_OUT    = w_out16[0];
  assign MAC3_OUT    = w_out8[3];
  assign MAC4_OUT    = w_out8[2];
  assign MAC5_OUT    = w_out8[1];
  assign MAC6_OUT    = w_out8[0];
  assign MAC_4_7_OUT = w_out4[7];
  assign MAC_4_6_OUT = w_out4[6];
  assign MAC_4_5_OUT = w_out4[5];
  assign MAC_4_4_OUT = w_out4[4];
  assign MAC_4_3_OUT = w_out4[3];
  assign MAC_4_2_OUT = w_out4[2];
  assign MAC_4_1_OUT = w_out4[1];
  assign MAC_4_0_OUT = w_out4[0];

endmodule

// File: tb/tb_mathb_mac_array.sv
// Bench for mathb_mac_array: directed examples plus randomized traffic, all
// compared against an arithmetic model of every lane's accumulator and output.
module tb_mathb_mac_array;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] oper;
  logic [31:0] coef;
  logic        tc;
  logic        clr;
  logic        rnd;
  logic        sat;
  logic [5:0]  sel;
  logic [31:0] mac0;
  logic [15:0] mac1, mac2;
  logic [7:0]  mac3, mac4, mac5, mac6;
  logic [3:0]  m47, m46, m45, m44, m43, m42, m41, m40;

  int n_total = 0;
  int n_bad   = 0;

  // Model accumulators: non-negative integers below 2^(2N), one per lane.
  logic signed [127:0] acc_m [15];

  mathb_mac_array dut (
    .MAC_ACC_CLK        (clk),
    .acc_ff_rstn        (rst_n),
    .EFPGA_MATHB_CLK_EN (en),
    .MAC_OPER_DATA      (oper),
    .MAC_COEF_DATA      (coef),
    .MAC_TC             (tc),
    .MAC_ACC_CLEAR      (clr),
    .MAC_ACC_RND        (rnd),
    .MAC_ACC_SAT        (sat),
    .MAC_OUT_SEL        (sel),
    .MAC0_OUT           (mac0),
    .MAC1_OUT           (mac1),
    .MAC2_OUT           (mac2),
    .MAC3_OUT           (mac3),
    .MAC4_OUT           (mac4),
    .MAC5_OUT           (mac5),
    .MAC6_OUT           (mac6),
    .MAC_4_7_OUT        (m47),
    .MAC_4_6_OUT        (m46),
    .MAC_4_5_OUT        (m45),
    .MAC_4_4_OUT        (m44),
    .MAC_4_3_OUT        (m43),
    .MAC_4_2_OUT        (m42),
    .MAC_4_1_OUT        (m41),
    .MAC_4_0_OUT        (m40)
  );

  always #5 clk = ~clk;

  // Lane map: 0 = MAC0, 1..2 = MAC1..2, 3..6 = MAC3..6, 7+k = MAC_4_k.
  function automatic int lane_n(input int i);
    if (i == 0) return 32;
    if (i < 3)  return 16;
    if (i < 7)  return 8;
    return 4;
  endfunction

  function automatic int lane_lsb(input int i);
    if (i == 0) return 0;
    if (i < 3)  return 16 * (2 - i);
    if (i < 7)  return 8 * (6 - i);
    return 4 * (i - 7);
  endfunction

  function automatic logic [31:0] dut_out(input int i);
    case (i)
      0:  return mac0;
      1:  return {16'd0, mac1};
      2:  return {16'd0, mac2};
      3:  return {24'd0, mac3};
      4:  return {24'd0, mac4};
      5:  return {24'd0, mac5};
      6:  return {24'd0, mac6};
      7:  return {28'd0, m40};
      8:  return {28'd0, m41};
      9:  return {28'd0, m42};
      10: return {28'd0, m43};
      11: return {28'd0, m44};
      12: return {28'd0, m45};
      13: return {28'd0, m46};
      default: return {28'd0, m47};
    endcase
  endfunction

  function automatic logic signed [127:0] slice_val(input logic [31:0] w, input int lsb,
                                                    input int n, input logic t);
    logic signed [127:0] u;
    logic signed [127:0] full;
    full = (128'sd1 <<< n);
    u = (128'(w) >> lsb) & (full - 128'sd1);
    if (t && (u >= (full >>> 1))) return u - full;
    return u;
  endfunction

  function automatic logic [31:0] model_out(input int i);
    int n;
    int s;
    logic signed [127:0] v;
    logic signed [127:0] lo;
    logic signed [127:0] hi;
    n = lane_n(i);
    s = (int'(sel) > n) ? n : int'(sel);
    v = acc_m[i];
    if (tc && (v >= (128'sd1 <<< (2 * n - 1)))) v = v - (128'sd1 <<< (2 * n));
    if (rnd && (s > 0)) v = v + (128'sd1 <<< (s - 1));
    v = v >>> s;
    if (tc) begin
      lo = -(128'sd1 <<< (n - 1));
      hi = (128'sd1 <<< (n - 1)) - 128'sd1;
    end else begin
      lo = 128'sd0;
      hi = (128'sd1 <<< n) - 128'sd1;
    end
    if (sat) begin
      if (v < lo) v = lo;
      if (v > hi) v = hi;
    end
    return 32'(v & ((128'sd1 <<< n) - 128'sd1));
  endfunction

  task automatic model_edge();
    int n;
    logic signed [127:0] p;
    logic signed [127:0] v;
    for (int i = 0; i < 15; i++) begin
      n = lane_n(i);
      p = slice_val(oper, lane_lsb(i), n, tc) * slice_val(coef, lane_lsb(i), n, tc);
      v = clr ? p : (acc_m[i] + p);
      acc_m[i] = v & ((128'sd1 <<< (2 * n)) - 128'sd1);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) acc_m[i] = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 15; i++) check($sformatf("%s_l%0d", tag, i), dut_out(i), model_out(i));
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 15; i++) check($sformatf("%s_l%0d", tag, i), dut_out(i), 32'd0);
  endtask

  task automatic set_ctrl(input logic t, input logic r, input logic s, input logic [5:0] sh);
    tc = t; rnd = r; sat = s; sel = sh;
    #1;
  endtask

  task automatic step(input logic e, input logic c, input logic [31:0] op, input logic [31:0] cf);
    en = e; clr = c; oper = op; coef = cf;
    @(posedge clk);
    if (e) model_edge();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; oper = 32'hDEADBEEF; coef = 32'h12345678;
    tc = 1'b0; rnd = 1'b0; sat = 1'b0; sel = 6'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst_a");
    set_ctrl(1'b1, 1'b1, 1'b1, 6'd3);
    check_zero("rst_b");
    set_ctrl(1'b0, 1'b1, 1'b0, 6'd63);
    check_zero("rst_c");

    rst_n = 1'b1;
    set_ctrl(1'b0, 1'b0, 1'b0, 6'd0);
    repeat (3) step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_zero("hold");

    // 32-bit unsigned accumulate
    step(1'b1, 1'b1, 32'd3, 32'd5);
    check("acc_e1", mac0, 32'd15);
    step(1'b1, 1'b0, 32'd3, 32'd5);
    check("acc_e2", mac0, 32'd30);
    step(1'b0, 1'b0, 32'd3, 32'd5);
    check("acc_hold", mac0, 32'd30);
    check_all("acc");

    // 8-bit signed lanes
    set_ctrl(1'b1, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b1, 32'hFF02_0304, 32'h05FE_0203);
    check("s8_mac3", {24'd0, mac3}, 32'hFB);
    check("s8_mac4", {24'd0, mac4}, 32'hFC);
    check("s8_mac5", {24'd0, mac5}, 32'h06);
    check("s8_mac6", {24'd0, mac6}, 32'h0C);
    check_all("s8");

    // 16-bit shift / round on MAC2 (accumulator 24)
    set_ctrl(1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b1, 32'h0000_0004, 32'h0000_0006);
    set_ctrl(1'b0, 1'b1, 1'b0, 6'd4);
    check("sh_rnd", {16'd0, mac2}, 32'd2);
    set_ctrl(1'b0, 1'b0, 1'b0, 6'd4);
    check("sh_trunc", {16'd0, mac2}, 32'd1);
    set_ctrl(1'b0, 1'b1, 1'b0, 6'd40);
    check("sh_clamp", {16'd0, mac2}, 32'd0);
    check_all("sh");

    // 4-bit saturation on nibble 0
    set_ctrl(1'b1, 1'b0, 1'b1, 6'd0);
    step(1'b1, 1'b1, 32'h0000_0007, 32'h0000_0007);
    check("sat_pos", {28'd0, m40}, 32'h7);
    set_ctrl(1'b1, 1'b0, 1'b0, 6'd0);
    check("sat_off", {28'd0, m40}, 32'h1);
    set_ctrl(1'b1, 1'b0, 1'b1, 6'd0);
    step(1'b1, 1'b1, 32'h0000_0008, 32'h0000_0007);
    check("sat_neg", {28'd0, m40}, 32'h8);
    set_ctrl(1'b1, 1'b0, 1'b1, 6'd63);
    check_all("sat");

    // Reset in the middle of an accumulation
    set_ctrl(1'b0, 1'b0, 1'b0, 6'd0);
    step(1'b1, 1'b1, 32'h0102_0304, 32'h0506_0708);
    repeat (4) step(1'b1, 1'b0, 32'h0102_0304, 32'h0506_0708);
    check_all("pre_rst");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero("mid_rst");
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'd2, 32'd2);
    check("post_rst", mac0, 32'd4);
    check_all("post_rst");

    // Randomized traffic, re-checking outputs under fresh output controls
    for (int k = 0; k < 400; k++) begin
      logic [31:0] op;
      logic [31:0] cf;
      op = $urandom();
      cf = $urandom();
      case ($urandom_range(0, 7))
        0: op = 32'hFFFF_FFFF;
        1: cf = 32'h8000_0000;
        2: op = 32'h7777_7777;
        default: ;
      endcase
      set_ctrl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8)));
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), op, cf);
      check_all($sformatf("rnd%0d", k));
      if ((k % 8) == 0) begin
        set_ctrl(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)));
        check_all($sformatf("ctl%0d", k));
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
